// File: rtl/pong_game_ctrl_if.sv
// Pong controller bus: VGA scan position, buttons and game outputs.
// The sync/board side is master, the game controller is slave.
interface pong_game_ctrl_if;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        btn_up;
    logic        btn_down;
    logic [11:0] rgb;
    logic [1:0]  lives;
    logic [6:0]  hits;
    logic [1:0]  game_state;

    modport master (
        output pixel_x, pixel_y, video_on, btn_up, btn_down,
        input  rgb, lives, hits, game_state
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, btn_up, btn_down,
        output rgb, lives, hits, game_state
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Frame-level Pong controller: ball/paddle motion, scoring, lives,
// and the registered pixel colour for the VGA RGB pins.
module pong_game_ctrl #(
    parameter int BALL_SIZE   = 8,
    parameter int BALL_V      = 2,
    parameter int PAD_H       = 72,
    parameter int PAD_V       = 4,
    parameter int WALL_L      = 32,
    parameter int WALL_R      = 35,
    parameter int PAD_XL      = 600,
    parameter int PAD_XR      = 603,
    parameter int LIVES       = 3,
    parameter int OVER_FRAMES = 120
) (
    input logic              clk,
    input logic              rst,
    pong_game_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_MISS = 2'b10,
        S_OVER = 2'b11
    } state_t;

    localparam logic [10:0] SZ  = 11'(BALL_SIZE);
    localparam logic [10:0] BV  = 11'(BALL_V);
    localparam logic [10:0] PH  = 11'(PAD_H);
    localparam logic [10:0] PV  = 11'(PAD_V);
    localparam logic [10:0] WL  = 11'(WALL_L);
    localparam logic [10:0] WR  = 11'(WALL_R);
    localparam logic [10:0] PXL = 11'(PAD_XL);
    localparam logic [10:0] PXR = 11'(PAD_XR);

    localparam logic [9:0] BX0  = 10'd316;
    localparam logic [9:0] BY0  = 10'd236;
    localparam logic [9:0] PAD0 = 10'd204;
    localparam logic [1:0] LIV  = 2'(LIVES);
    localparam logic [6:0] OVER_LAST = 7'(OVER_FRAMES - 1);

    state_t      state;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic [9:0]  pad_y;
    logic        dx_pos;
    logic        dy_pos;
    logic [1:0]  lives_q;
    logic [6:0]  hits_q;
    logic [6:0]  over_cnt;
    logic        cond_r;
    logic        cond_rr;
    logic [11:0] rgb_q;

    logic [10:0] bx, by, py, px, pyy;
    logic        cond, tick;
    logic        up_only, dn_only;
    logic        hit, miss;
    logic        ndx, ndy;
    logic [10:0] nbx, nby;
    logic [9:0]  pad_nxt;
    logic        ball_pix, pad_pix, wall_pix;

    assign bx  = {1'b0, ball_x};
    assign by  = {1'b0, ball_y};
    assign py  = {1'b0, pad_y};
    assign px  = {1'b0, bus.pixel_x};
    assign pyy = {1'b0, bus.pixel_y};

    assign cond = (bus.pixel_y == 10'd481) && (bus.pixel_x == 10'd0);
    assign tick = cond_r & ~cond_rr;

    assign up_only = bus.btn_up & ~bus.btn_down;
    assign dn_only = bus.btn_down & ~bus.btn_up;

    assign miss = bx >= (11'd640 - SZ);

    // Next direction and position; walls first, then the paddle.
    always_comb begin
        ndy = dy_pos;
        if (by <= BV) ndy = 1'b1;
        if (by + SZ >= 11'd480 - BV) ndy = 1'b0;
        ndx = dx_pos;
        if (bx <= WR + 11'd1) ndx = 1'b1;
        hit = dx_pos
            && (bx + SZ - 11'd1 >= PXL)
            && (bx + SZ - 11'd1 <= PXR)
            && (by + SZ - 11'd1 >= py)
            && (by <= py + PH - 11'd1);
        if (hit) ndx = 1'b0;
        nbx = ndx ? bx + BV : bx - BV;
        nby = ndy ? by + BV : by - BV;
    end

    // Paddle step, held at the top and bottom limits.
    always_comb begin
        pad_nxt = pad_y;
        if (up_only && py >= PV)
            pad_nxt = pad_y - PV[9:0];
        else if (dn_only && py + PH + PV <= 11'd480)
            pad_nxt = pad_y + PV[9:0];
    end

    assign ball_pix = (state == S_PLAY)
        && px >= bx && px < bx + SZ
        && pyy >= by && pyy < by + SZ;
    assign pad_pix = px >= PXL && px <= PXR
        && pyy >= py && pyy < py + PH;
    assign wall_pix = px >= WL && px <= WR;

    // Game state machine, frame tick detection and all game state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            ball_x   <= BX0;
            ball_y   <= BY0;
            dx_pos   <= 1'b1;
            dy_pos   <= 1'b1;
            pad_y    <= PAD0;
            lives_q  <= LIV;
            hits_q   <= 7'd0;
            over_cnt <= 7'd0;
            cond_r   <= 1'b0;
            cond_rr  <= 1'b0;
        end else begin
            cond_r  <= cond;
            cond_rr <= cond_r;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        pad_y <= pad_nxt;
                        if (bus.btn_up | bus.btn_down)
                            state <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        pad_y <= pad_nxt;
                        if (miss) begin
                            state <= S_MISS;
                        end else begin
                            ball_x <= nbx[9:0];
                            ball_y <= nby[9:0];
                            dx_pos <= ndx;
                            dy_pos <= ndy;
                            if (hit && hits_q < 7'd99)
                                hits_q <= hits_q + 7'd1;
                        end
                    end
                end
                S_MISS: begin
                    ball_x <= BX0;
                    ball_y <= BY0;
                    dx_pos <= 1'b1;
                    dy_pos <= 1'b1;
                    if (lives_q == 2'd1) begin
                        lives_q <= 2'd0;
                        state   <= S_OVER;
                    end else begin
                        lives_q <= lives_q - 2'd1;
                        state   <= S_IDLE;
                    end
                end
                S_OVER: begin
                    if (tick) begin
                        if (over_cnt == OVER_LAST) begin
                            state    <= S_IDLE;
                            lives_q  <= LIV;
                            hits_q   <= 7'd0;
                            over_cnt <= 7'd0;
                        end else begin
                            over_cnt <= over_cnt + 7'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pixel colour, one clock behind the scan position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               rgb_q <= 12'h000;
        else if (!bus.video_on) rgb_q <= 12'h000;
        else if (ball_pix)      rgb_q <= 12'hF00;
        else if (pad_pix)       rgb_q <= 12'h0F0;
        else if (wall_pix)      rgb_q <= 12'h00F;
        else                    rgb_q <= 12'h000;
    end

    assign bus.rgb        = rgb_q;
    assign bus.lives      = lives_q;
    assign bus.hits       = hits_q;
    assign bus.game_state = state;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: pixel table, scoreboarded colour probes,
// and a behavioural game model played against the DUT frame by frame.
module tb_pong_game_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pong_game_ctrl_if bus();

    pong_game_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          x;
        int          y;
        bit          v;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[14];
    logic [11:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;

    // behavioural game model: state 0 idle,1 play,2 miss,3 over
    int m_st, m_bx, m_by, m_dx, m_dy, m_pad;
    int m_lives, m_hits, m_oc;

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
        m_pad = 204; m_lives = 3; m_hits = 0; m_oc = 0;
    endtask

    function automatic int colour(int x, int y, bit v);
        if (!v) return 0;
        if (m_st == 1 && x >= m_bx && x < m_bx + 8
            && y >= m_by && y < m_by + 8) return 'hF00;
        if (x >= 600 && x <= 603 && y >= m_pad && y < m_pad + 72)
            return 'h0F0;
        if (x >= 32 && x <= 35) return 'h00F;
        return 0;
    endfunction

    task automatic model_tick(bit up, bit dn);
        int np;
        np = m_pad;
        if (m_st <= 1) begin
            if (up && !dn && m_pad >= 4) np = m_pad - 4;
            else if (dn && !up && m_pad + 76 <= 480) np = m_pad + 4;
        end
        if (m_st == 0) begin
            if (up || dn) m_st = 1;
        end else if (m_st == 1) begin
            if (m_bx >= 632) begin
                m_st = 2;
            end else begin
                if (m_by <= 2) m_dy = 1;
                if (m_by + 8 >= 478) m_dy = -1;
                if (m_bx <= 36) m_dx = 1;
                if (m_dx > 0 && m_bx + 7 >= 600 && m_bx + 7 <= 603
                    && m_by + 7 >= m_pad && m_by <= m_pad + 71) begin
                    m_dx = -1;
                    if (m_hits < 99) m_hits++;
                end
                m_bx += 2 * m_dx;
                m_by += 2 * m_dy;
            end
        end else if (m_st == 3) begin
            if (m_oc == 119) begin
                m_st = 0; m_lives = 3; m_hits = 0; m_oc = 0;
            end else begin
                m_oc++;
            end
        end
        m_pad = np;
    endtask

    task automatic model_miss();
        if (m_st == 2) begin
            m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
            if (m_lives == 1) begin
                m_lives = 0; m_st = 3;
            end else begin
                m_lives--; m_st = 0;
            end
        end
    endtask

    task automatic probe_exp(int x, int y, bit v, logic [11:0] e);
        logic [11:0] want;
        bus.pixel_x = 10'(x);
        bus.pixel_y = 10'(y);
        bus.video_on = v;
        exp_q.push_back(e);
        @(posedge clk); #1;
        want = exp_q.pop_front();
        check($sformatf("rgb(%0d,%0d,%0d)", x, y, v), int'(bus.rgb),
              int'(want));
    endtask

    task automatic probe(int x, int y);
        probe_exp(x, y, 1'b1, 12'(colour(x, y, 1'b1)));
    endtask

    task automatic probe_scene();
        probe(601, m_pad);
        if (m_pad > 0) probe(601, m_pad - 1);
        probe(601, m_pad + 71);
        probe(601, m_pad + 72);
        if (m_st == 1) begin
            probe(m_bx, m_by);
            probe(m_bx + 7, m_by + 7);
            probe(m_bx - 1, m_by);
            probe(m_bx + 8, m_by + 7);
            probe(m_bx, m_by + 8);
            probe(m_bx + 7, m_by - 1);
        end
    endtask

    // one frame: tick condition held 4 clks, then scene probes
    task automatic frame(bit up, bit dn);
        bus.btn_up = up;
        bus.btn_down = dn;
        bus.video_on = 1'b0;
        bus.pixel_y = 10'd481;
        bus.pixel_x = 10'd0;
        @(posedge clk); @(posedge clk); #1;
        model_tick(up, dn);
        check("state_at_tick", int'(bus.game_state), m_st);
        model_miss();
        @(posedge clk); @(posedge clk); #1;
        bus.pixel_x = 10'd1;
        @(posedge clk); #1;
        check("state", int'(bus.game_state), m_st);
        check("lives", int'(bus.lives), m_lives);
        check("hits", int'(bus.hits), m_hits);
        probe_scene();
    endtask

    task automatic bot_frame();
        int pc, bc;
        pc = m_pad + 36;
        bc = m_by + 4;
        if (m_st == 0) frame(1'b0, 1'b1);
        else if (pc < bc - 2) frame(1'b0, 1'b1);
        else if (pc > bc + 2) frame(1'b1, 1'b0);
        else frame(1'b0, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{33, 100, 1'b1, 12'h00F};
        tbl[1]  = '{32, 0, 1'b1, 12'h00F};
        tbl[2]  = '{35, 479, 1'b1, 12'h00F};
        tbl[3]  = '{31, 100, 1'b1, 12'h000};
        tbl[4]  = '{36, 100, 1'b1, 12'h000};
        tbl[5]  = '{601, 204, 1'b1, 12'h0F0};
        tbl[6]  = '{601, 275, 1'b1, 12'h0F0};
        tbl[7]  = '{601, 203, 1'b1, 12'h000};
        tbl[8]  = '{601, 276, 1'b1, 12'h000};
        tbl[9]  = '{600, 240, 1'b1, 12'h0F0};
        tbl[10] = '{604, 240, 1'b1, 12'h000};
        tbl[11] = '{33, 100, 1'b0, 12'h000};
        tbl[12] = '{316, 236, 1'b1, 12'h000};
        tbl[13] = '{601, 240, 1'b0, 12'h000};

        rst = 1'b0;
        bus.pixel_x = 10'd0;
        bus.pixel_y = 10'd0;
        bus.video_on = 1'b0;
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_rgb", int'(bus.rgb), 0);
        check("rst_lives", int'(bus.lives), 3);
        check("rst_hits", int'(bus.hits), 0);
        check("rst_state", int'(bus.game_state), 0);

        for (int i = 0; i < 14; i++)
            probe_exp(tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].exp);

        // a non-matching scan position must not tick
        bus.btn_down = 1'b1;
        bus.pixel_y = 10'd481;
        bus.pixel_x = 10'd2;
        repeat (4) @(posedge clk);
        #1;
        check("no_tick_state", int'(bus.game_state), 0);
        probe_scene();

        repeat (3) frame(1'b0, 1'b0);
        repeat (60) frame(1'b1, 1'b0);
        repeat (5) frame(1'b1, 1'b1);
        repeat (110) frame(1'b0, 1'b1);
        repeat (600) bot_frame();

        // asynchronous reset in the middle of a game
        frame(1'b0, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_rgb", int'(bus.rgb), 0);
        check("mid_rst_state", int'(bus.game_state), 0);
        check("mid_rst_lives", int'(bus.lives), 3);
        check("mid_rst_hits", int'(bus.hits), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        probe_scene();

        for (int i = 0; i < 2000 && m_st != 3; i++)
            frame(1'b1, 1'b0);
        check("reach_over", int'(bus.game_state), 3);
        check("over_lives", int'(bus.lives), 0);
        repeat (119) frame(1'b0, 1'b0);
        check("over_hold", int'(bus.game_state), 3);
        frame(1'b0, 1'b0);
        check("over_exit", int'(bus.game_state), 0);
        check("over_lives3", int'(bus.lives), 3);
        check("over_hits0", int'(bus.hits), 0);
        repeat (5) frame(1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
